// File: rtl/multi_clk_en_pkg.sv
// Shared definitions for the multi-channel clock-enable generator.
// Holds the divisor floor, the nominal system clock rate, the reset divisor,
// the per-channel configuration record and the clamp applied on every
// configuration write.
package multi_clk_en_pkg;

  // Width of the configuration record; channel counters may be narrower.
  localparam int CFG_W       = 28;
  localparam int CLK_HZ      = 100000000;
  localparam int DEFAULT_DIV = 100000000;

  localparam logic [CFG_W-1:0] DIV_MIN = 28'd2;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
  } ch_cfg_t;

  // Divisor is floored at DIV_MIN; high time never exceeds the stored divisor,
  // so high == div gives a constant-1 wave and high == 0 a constant-0 wave.
  function automatic ch_cfg_t clamp_cfg(input logic [CFG_W-1:0] div_in,
                                        input logic [CFG_W-1:0] high_in);
    ch_cfg_t cfg;
    if (div_in < DIV_MIN) begin
      cfg.div = DIV_MIN;
    end else begin
      cfg.div = div_in;
    end
    if (high_in > cfg.div) begin
      cfg.high = cfg.div;
    end else begin
      cfg.high = high_in;
    end
    return cfg;
  endfunction

endpackage

// File: rtl/multi_clk_en_gen_ch.sv
// clk_en_ch: one clock-enable channel.
// Counts 0..div-1 while enabled and produces a registered one-cycle tick in
// the cycle the counter shows div-1, plus a registered PWM level that is high
// while the counter is >= div-high. New settings land in a shadow and are
// promoted to the active pair only where a fresh period starts.
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   en                  run enable; low holds the counter at 0
//   restart             force a new period on the next edge (if enabled)
//   wr                  write strobe for this channel (already clamped data)
//   wr_div, wr_high     clamped period / high time
//   tick, wave          registered tick pulse and PWM level
//   pending             shadow holds a write not yet promoted
module clk_en_ch #(
  parameter int               CNT_W    = 28,
  parameter logic [CNT_W-1:0] RST_DIV  = CNT_W'(2),
  parameter logic [CNT_W-1:0] RST_HIGH = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  output logic             tick,
  output logic             wave,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_r, div_r, high_r, sdiv_r, shigh_r;
  logic             run_r, pend_r, tick_r, wave_r;

  logic [CNT_W-1:0] cnt_nxt_s, div_nxt_s, high_nxt_s, sdiv_nxt_s, shigh_nxt_s;
  logic             pend_nxt_s, tick_nxt_s, wave_nxt_s;
  logic             wrap_s, fresh_s, apply_s;

  // Next-state: counter, shadow promotion, shadow capture and output levels.
  always_comb begin
    wrap_s  = (cnt_r == (div_r - CNT_W'(1)));
    // A new period (or idle) begins on this edge: disabled, first enabled
    // edge after idle, forced restart, or natural wrap after the tick cycle.
    fresh_s = !en || !run_r || restart || wrap_s;
    apply_s = pend_r && fresh_s;

    if (apply_s) begin
      div_nxt_s  = sdiv_r;
      high_nxt_s = shigh_r;
    end else begin
      div_nxt_s  = div_r;
      high_nxt_s = high_r;
    end

    if (fresh_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end

    // A write coinciding with a promotion is kept for the next boundary;
    // the promotion above uses the shadow contents from before the write.
    if (wr) begin
      sdiv_nxt_s  = wr_div;
      shigh_nxt_s = wr_high;
      pend_nxt_s  = 1'b1;
    end else begin
      sdiv_nxt_s  = sdiv_r;
      shigh_nxt_s = shigh_r;
      pend_nxt_s  = pend_r && !apply_s;
    end

    // Outputs are computed from next-state values so that the registered
    // tick/wave line up with the registered counter.
    if (en && !restart) begin
      tick_nxt_s = (cnt_nxt_s == (div_nxt_s - CNT_W'(1)));
      wave_nxt_s = (cnt_nxt_s >= (div_nxt_s - high_nxt_s));
    end else begin
      tick_nxt_s = 1'b0;
      wave_nxt_s = 1'b0;
    end
  end

  // Channel state registers with asynchronous reset to the default setting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= {CNT_W{1'b0}};
      div_r   <= RST_DIV;
      high_r  <= RST_HIGH;
      sdiv_r  <= RST_DIV;
      shigh_r <= RST_HIGH;
      run_r   <= 1'b0;
      pend_r  <= 1'b0;
      tick_r  <= 1'b0;
      wave_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      div_r   <= div_nxt_s;
      high_r  <= high_nxt_s;
      sdiv_r  <= sdiv_nxt_s;
      shigh_r <= shigh_nxt_s;
      run_r   <= en;
      pend_r  <= pend_nxt_s;
      tick_r  <= tick_nxt_s;
      wave_r  <= wave_nxt_s;
    end
  end

  assign tick    = tick_r;
  assign wave    = wave_r;
  assign pending = pend_r;

endmodule

// File: rtl/multi_clk_en_gen.sv
// multi_clk_en_gen: NUM_CH independent clock-enable generators on one clock.
// Decodes the configuration write to a channel, clamps the written values
// and instantiates one clk_en_ch per channel. No derived clocks leave here.
// Optional feature macro: SYNC_RESTART_EN (adds input sync_restart, which
// restarts every enabled channel at cnt=0 and promotes pending shadows).
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   ch_en               per-channel run enable
//   cfg_wr, cfg_ch      write strobe and target channel (out of range ignored)
//   cfg_div, cfg_high   requested period / high time in clk cycles
//   sync_restart        (SYNC_RESTART_EN only) phase-align all channels
//   tick, wave          per-channel registered tick and PWM level
//   cfg_pending         per-channel shadow-not-yet-active flag
module multi_clk_en_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = multi_clk_en_pkg::DEFAULT_DIV,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
`ifdef SYNC_RESTART_EN
  input  logic              sync_restart,
`endif
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] wave,
  output logic [NUM_CH-1:0] cfg_pending
);

  import multi_clk_en_pkg::*;

  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_DIV / 2);

  ch_cfg_t          clamped_s;
  logic [CNT_W-1:0] wr_div_s, wr_high_s;
  logic [NUM_CH-1:0] wr_sel_s;
  logic             restart_s;

  // Clamp the written divisor/high time once for all channels.
  always_comb begin
    clamped_s = clamp_cfg(CFG_W'(cfg_div), CFG_W'(cfg_high));
    wr_div_s  = clamped_s.div[CNT_W-1:0];
    wr_high_s = clamped_s.high[CNT_W-1:0];
  end

  // One-hot write select; a cfg_ch beyond the last channel selects nothing.
  always_comb begin
    wr_sel_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_wr && (32'(cfg_ch) == i)) begin
        wr_sel_s[i] = 1'b1;
      end else begin
        wr_sel_s[i] = 1'b0;
      end
    end
  end

`ifdef SYNC_RESTART_EN
  assign restart_s = sync_restart;
`else
  assign restart_s = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_en_ch #(
      .CNT_W    (CNT_W),
      .RST_DIV  (RST_DIV),
      .RST_HIGH (RST_HIGH)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (ch_en[g]),
      .restart  (restart_s),
      .wr       (wr_sel_s[g]),
      .wr_div   (wr_div_s),
      .wr_high  (wr_high_s),
      .tick     (tick[g]),
      .wave     (wave[g]),
      .pending  (cfg_pending[g])
    );
  end

endmodule

// File: tb/tb_multi_clk_en_gen.sv
// Self-checking bench for multi_clk_en_gen (NUM_CH=4, CNT_W=8, DEFAULT_DIV=20)
// plus a NUM_CH=5 instance used to exercise an out-of-range cfg_ch.
// The reference model tracks, per channel, the edge at which the current
// period began and the active/shadow settings as plain integers.
module tb_multi_clk_en_gen;

  localparam int NCH = 4;
  localparam int DDIV = 20;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [NCH-1:0] ch_en = '0;
  logic           cfg_wr = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [7:0]     cfg_div = '0;
  logic [7:0]     cfg_high = '0;
  logic           sync_restart = 1'b0;
  logic [NCH-1:0] tick, wave, cfg_pending;

  logic [4:0] ch_en5 = '0;
  logic       cfg_wr5 = 1'b0;
  logic [2:0] cfg_ch5 = '0;
  logic [4:0] tick5, wave5, pend5;

  int ncmp = 0;
  int nfail = 0;

  // reference model state
  int m_div[NCH], m_high[NCH], m_sdiv[NCH], m_shigh[NCH], m_start[NCH];
  bit m_run[NCH];
  bit [NCH-1:0] e_tick, e_wave, e_pend;
  int edge_n = 0;

  always #5 clk = ~clk;

  multi_clk_en_gen #(.NUM_CH(NCH), .CNT_W(8), .DEFAULT_DIV(DDIV)) dut (
    .clk(clk), .reset_n(reset_n), .ch_en(ch_en), .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high),
`ifdef SYNC_RESTART_EN
    .sync_restart(sync_restart),
`endif
    .tick(tick), .wave(wave), .cfg_pending(cfg_pending)
  );

  multi_clk_en_gen #(.NUM_CH(5), .CNT_W(8), .DEFAULT_DIV(DDIV)) dut5 (
    .clk(clk), .reset_n(reset_n), .ch_en(ch_en5), .cfg_wr(cfg_wr5),
    .cfg_ch(cfg_ch5), .cfg_div(cfg_div), .cfg_high(cfg_high),
`ifdef SYNC_RESTART_EN
    .sync_restart(1'b0),
`endif
    .tick(tick5), .wave(wave5), .cfg_pending(pend5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = DDIV; m_high[i] = DDIV / 2;
      m_sdiv[i] = DDIV; m_shigh[i] = DDIV / 2;
      m_run[i] = 1'b0; m_start[i] = edge_n;
    end
    e_tick = '0; e_wave = '0; e_pend = '0;
  endtask

  // Apply the spec rules for one clock edge using the inputs sampled there.
  task automatic model_edge();
    int pos, d, h;
    bit boundary, rst_now, fresh;
    edge_n++;
    for (int i = 0; i < NCH; i++) begin
      boundary = m_run[i] && ((edge_n - 1 - m_start[i]) == m_div[i] - 1);
      rst_now  = sync_restart && ch_en[i];
      fresh    = !ch_en[i] || !m_run[i] || rst_now || boundary;
      if (e_pend[i] && fresh) begin
        m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; e_pend[i] = 1'b0;
      end
      if (cfg_wr && (cfg_ch == i)) begin
        d = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
        h = (int'(cfg_high) > d) ? d : int'(cfg_high);
        m_sdiv[i] = d; m_shigh[i] = h; e_pend[i] = 1'b1;
      end
      if (fresh) m_start[i] = edge_n;
      m_run[i] = ch_en[i];
      pos = edge_n - m_start[i];
      e_tick[i] = ch_en[i] && !rst_now && (pos == m_div[i] - 1);
      e_wave[i] = ch_en[i] && !rst_now && (pos >= m_div[i] - m_high[i]);
    end
  endtask

  task automatic check_outputs();
    chk("tick", 32'(tick), 32'(e_tick));
    chk("wave", 32'(wave), 32'(e_wave));
    chk("cfg_pending", 32'(cfg_pending), 32'(e_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic write_cfg(input int ch, input int d, input int h);
    cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_div = 8'(d); cfg_high = 8'(h);
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic random_phase(input int n);
    int b;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        b = $urandom_range(0, NCH - 1);
        ch_en[b] = ~ch_en[b];
      end
      cfg_wr   = ($urandom_range(0, 5) == 0);
      cfg_ch   = 2'($urandom_range(0, NCH - 1));
      cfg_div  = 8'($urandom_range(0, 12));
      cfg_high = 8'($urandom_range(0, 14));
`ifdef SYNC_RESTART_EN
      sync_restart = ($urandom_range(0, 39) == 0);
`endif
      step();
    end
    cfg_wr = 1'b0;
    sync_restart = 1'b0;
  endtask

  initial begin
    int first, second, wcnt, pc, k, t0, t2;
    bit all1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // ch0: write while disabled, pending pulses one cycle, then enable
    write_cfg(0, 10, 3);
    chk("t1_pend_pulse", 32'(cfg_pending), 32'h1);
    step();
    chk("t1_pend_clear", 32'(cfg_pending), 32'h0);
    ch_en[0] = 1'b1;
    first = -1; second = -1; wcnt = 0;
    for (int j = 1; j <= 25; j++) begin
      step();
      if (tick[0]) begin
        if (first < 0) first = j;
        else if (second < 0) second = j;
      end
      if (j >= 11 && j <= 20 && wave[0]) wcnt++;
      if (j == 20) chk("t1_wave_on_tick", 32'(wave[0]), 32'h1);
    end
    chk("t1_first_tick", 32'(first), 32'd10);
    chk("t1_second_tick", 32'(second), 32'd20);
    chk("t1_wave_high_cnt", 32'(wcnt), 32'd3);

    // ch1: running at 8, write 5 so pending shows from cnt=2
    write_cfg(1, 8, 4);
    step();
    ch_en[1] = 1'b1;
    repeat (10) step();
    k = 0;
    while (k < 30 && !(m_run[1] && (edge_n - m_start[1]) == 1)) begin
      step(); k++;
    end
    chk("t2_sync_timeout", 32'(k < 30), 32'h1);
    write_cfg(1, 5, 2);
    pc = 0;
    for (int j = 0; j < 20; j++) begin
      if (cfg_pending[1]) pc++;
      step();
    end
    chk("t2_pend_cycles", 32'(pc), 32'd6);

    // ch2: div=1/high=0 -> period 2 wave 0; then div=6/high=9 -> wave 1
    write_cfg(2, 1, 0);
    step();
    ch_en[2] = 1'b1;
    repeat (8) step();
    write_cfg(2, 6, 9);
    all1 = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      if (j >= 14) all1 = all1 & wave[2];
    end
    chk("t3_wave_const1", 32'(all1), 32'h1);

    // ch3: write in its tick cycle is deferred one full period
    ch_en[3] = 1'b1;
    k = 0;
    while (k < 45 && !tick[3]) begin
      step(); k++;
    end
    chk("t4_tick_timeout", 32'(tick[3]), 32'h1);
    write_cfg(3, 4, 1);
    k = 1;
    while (k < 45 && !tick[3]) begin
      step(); k++;
    end
    chk("t4_deferred_period", 32'(k), 32'd20);
    step();
    k = 1;
    while (k < 45 && !tick[3]) begin
      step(); k++;
    end
    chk("t4_new_period", 32'(k), 32'd4);

    // out-of-range channel on a 5-channel build changes nothing
    cfg_div = 8'd3; cfg_high = 8'd1;
    cfg_wr5 = 1'b1; cfg_ch5 = 3'd6;
    step();
    cfg_wr5 = 1'b0;
    chk("t5_oor_pending", 32'(pend5), 32'h0);
    step();
    chk("t5_oor_pending2", 32'(pend5), 32'h0);
    cfg_wr5 = 1'b1; cfg_ch5 = 3'd4;
    step();
    cfg_wr5 = 1'b0;
    chk("t5_ch4_pending", 32'(pend5), 32'h10);
    step();
    chk("t5_ch4_clear", 32'(pend5), 32'h0);

    // randomized traffic
    random_phase(700);

    // pending write lost on a mid-period reset
    ch_en = 4'b0001;
    repeat (3) step();
    write_cfg(0, 3, 1);
    step();
    do_reset();
    first = -1;
    for (int j = 1; j <= 25; j++) begin
      step();
      if (tick[0] && first < 0) first = j;
    end
    chk("t6_default_after_reset", 32'(first), 32'd20);

`ifdef SYNC_RESTART_EN
    ch_en = '0;
    step();
    write_cfg(0, 7, 3);
    write_cfg(2, 5, 2);
    step();
    ch_en = 4'b0101;
    repeat (13) step();
    write_cfg(2, 9, 4);
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    chk("t7_restart_tick", 32'(tick), 32'h0);
    t0 = -1; t2 = -1;
    for (int j = 2; j <= 20; j++) begin
      step();
      if (tick[0] && t0 < 0) t0 = j;
      if (tick[2] && t2 < 0) t2 = j;
    end
    chk("t7_ch0_after_restart", 32'(t0), 32'd7);
    chk("t7_ch2_after_restart", 32'(t2), 32'd9);
    repeat (4) step();
    do_reset();
    random_phase(100);
`else
    t0 = 0; t2 = 0;
    random_phase(150);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
